// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
// Holds digit width, default sizes, validity and adjust thresholds.
package bcd_pkg;

   localparam int DIG_W    = 4;
   localparam int NDIG_DEF = 3;
   localparam int BW_DEF   = 10;

   localparam logic [DIG_W-1:0] DIG_MAX  = 4'd9;
   localparam logic [DIG_W-1:0] ADJ_TH   = 4'd8;
   localparam logic [DIG_W-1:0] ADJ_CORR = 4'd3;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   function automatic logic digit_bad(
      input logic [DIG_W-1:0] d
   );
      return d > DIG_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_sub3.sv
// One BCD digit adjust for reverse double-dabble.
// Ports: d_i digit after shift, q_o digit minus 3 when d_i >= 8.
module bcd_digit_sub3
   import bcd_pkg::*;
(
   input  logic [DIG_W-1:0] d_i,
   output logic [DIG_W-1:0] q_o
);

   // A shifted digit is >=8 only when a 1 came in from the
   // digit above, so subtracting 3 never wraps below zero.
   assign q_o = (d_i >= ADJ_TH) ? (d_i - ADJ_CORR) : d_i;

endmodule

// File: rtl/bcd2bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// Ports: clk, rst (sync, high), start, bcd_in -> busy, done, bin_out, err.
module bcd2bin
   import bcd_pkg::*;
#(
   parameter int NDIG = NDIG_DEF,
   parameter int BW   = BW_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIG_W*NDIG-1:0] bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BW-1:0]         bin_out,
   output logic                  err
);

   localparam int BCD_W = DIG_W * NDIG;
   localparam int CAT_W = BCD_W + BW;
   localparam int CW    = $clog2(BW + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(BW - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      bin_q, bin_d;
   logic               err_q, err_d;
   logic               done_q, done_d;

   logic [CAT_W-1:0]   cat_shr;
   logic [BCD_W-1:0]   bcd_adj;
   logic [BW-1:0]      acc_shr;
   logic [NDIG-1:0]    dig_bad;
   logic               any_bad;

   // One step: LSB of the BCD field falls into the acc MSB.
   assign cat_shr = {bcd_q, acc_q} >> 1;
   assign acc_shr = cat_shr[BW-1:0];

   for (genvar g = 0; g < NDIG; g++) begin : g_dig
      bcd_digit_sub3 u_sub3 (
         .d_i (cat_shr[BW + g*DIG_W +: DIG_W]),
         .q_o (bcd_adj[g*DIG_W +: DIG_W])
      );
      assign dig_bad[g] = digit_bad(bcd_in[g*DIG_W +: DIG_W]);
   end

   assign any_bad = |dig_bad;

   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      err_d   = err_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               bcd_d = bcd_in;
               acc_d = '0;
               cnt_d = '0;
               if (any_bad) begin
                  bin_d  = '0;
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            bcd_d = bcd_adj;
            acc_d = acc_shr;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               // Result taken from the post-step acc so the
               // BW-th step lands on bin_out in the same edge.
               bin_d   = acc_shr;
               err_d   = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         bcd_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bin_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign busy    = (state_q == S_SHIFT);
   assign done    = done_q;
   assign bin_out = bin_q;
   assign err     = err_q;

endmodule
